fetch_unit: RTL

Instruction fetch unit on the consumer side of the program counter. Takes the current PC and reads the instruction at that address from instruction memory over a request/acknowledge handshake. Buffers up to two fetched instructions, each tagged with its PC, for the decoder. Drives the PC's enable so the PC advances only when a fetch completes or a branch loads.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and the
// buffered {instruction, pc} entry handed to the decoder.
package fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer. Entry 0 is always the head, so the
// head output keeps its last value once the buffer drains.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    logic [1:0]   count_q;
    fetch_entry_t e0_q, e1_q;
    logic         do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    assign count_o = count_q;
    assign head_o  = e0_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else if (clear_i) begin
            count_q <= 2'd0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= entry_i;
                    else                 e1_q <= entry_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) e0_q <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new entry slides in behind the survivor.
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= entry_i;
                    end else begin
                        e0_q <= entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads the instruction at PC_in over a req/ack
// handshake, buffers up to two tagged instructions and drives the PC enable.
module fetch_unit #(
    parameter int ADDR_W    = fetch_pkg::ADDR_W,
    parameter int INSTR_W   = fetch_pkg::INSTR_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [ADDR_W-1:0]  PC_in,
    input  logic               Flush,
    output logic               PC_Enable,
    output logic               Mem_Req,
    output logic [ADDR_W-1:0]  Mem_Addr,
    input  logic               Mem_Ack,
    input  logic [INSTR_W-1:0] Mem_RData,
    output logic               Instr_Valid,
    output logic [INSTR_W-1:0] Instr_out,
    output logic [ADDR_W-1:0]  Instr_PC,
    input  logic               Instr_Ready
);

    import fetch_pkg::*;

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    fetch_state_t      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              push, pop;
    logic [1:0]        count;
    fetch_entry_t      head, new_entry;

    assign push        = (state_q == REQ) & Mem_Ack & ~Flush;
    assign pop         = Instr_Valid & Instr_Ready;
    assign Instr_Valid = (count != 2'd0);
    // A taken branch always enables the PC so it loads the target.
    assign PC_Enable   = Reset_n & (Flush | push);
    assign Mem_Req     = req_q;
    assign Mem_Addr    = addr_q;
    assign Instr_out   = head.instr;
    assign Instr_PC    = head.pc;
    assign new_entry   = '{instr: Mem_RData, pc: addr_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!Flush && count < DEPTH) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= PC_in;
                    end
                end
                REQ: begin
                    // The request is never withdrawn; a flush only marks its data as dead.
                    if (Mem_Ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else if (Flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (Mem_Ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer u_buf (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .push_i  (push),
        .entry_i (new_entry),
        .pop_i   (pop),
        .clear_i (Flush),
        .count_o (count),
        .head_o  (head)
    );

endmodule
